regfile_multiport: RTL and testbench

//  Parametrised integer register file for the 5-stage RV32I pipeline: NRD async read ports,
//  one sync write port with write-to-read bypass, hardwired-zero x0, and a per-register

---
 rtl/regfile_multiport.sv | 133 +++++++++++++
 tb/tb_regfile_multiport.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// Multi-port integer register file: async reads with optional write bypass,
// busy scoreboard for hazard detection, and a valid/ready dump engine.
module regfile_multiport #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr,
    input  logic                sb_flush,
    output logic [NREGS-1:0]    busy,
    input  logic                dump_req,
    output logic                dump_valid,
    input  logic                dump_ready,
    output logic [AW-1:0]       dump_addr,
    output logic [XLEN-1:0]     dump_data,
    output logic                dump_last,
    output logic                dump_done
);

    localparam logic [1:0]    S_IDLE   = 2'd0;
    localparam logic [1:0]    S_RUN    = 2'd1;
    localparam logic [1:0]    S_DONE   = 2'd2;
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    logic [XLEN-1:0]  regs [NREGS];
    logic             wr_en;
    logic [NREGS-1:0] busy_next;
    logic [1:0]       state;
    logic [AW-1:0]    idx;

    // A write to x0 is dropped entirely when it is hardwired, including for bypass.
    assign wr_en = we && !(ZERO_REG && waddr == '0);

    // NOTE: the whole array is cleared on reset so software sees zeros before first write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                // NOTE: non-blocking for all sequential state, so every reader sees the pre-edge value.
                regs[r] <= '0;
            end
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves the output unassigned (no latch).
        rdata = '0;
        for (int p = 0; p < NRD; p++) begin
            if (ZERO_REG && raddr[p*AW +: AW] == '0) begin
                rdata[p*XLEN +: XLEN] = '0;
            end else if (BYPASS && wr_en && waddr == raddr[p*AW +: AW]) begin
                rdata[p*XLEN +: XLEN] = wdata;
            end else begin
                rdata[p*XLEN +: XLEN] = regs[raddr[p*AW +: AW]];
            end
        end
    end

    // A set and a write to the same index in one cycle leaves it busy: the set is the newer producer.
    always_comb begin
        busy_next = busy;
        for (int r = 0; r < NREGS; r++) begin
            if (sb_flush) begin
                busy_next[r] = 1'b0;
            end else if (sb_set && sb_addr == AW'(r)) begin
                busy_next[r] = 1'b1;
            end else if (we && waddr == AW'(r)) begin
                busy_next[r] = 1'b0;
            end
        end
        if (ZERO_REG) begin
            busy_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dump_req) begin
                        state <= S_RUN;
                        idx   <= '0;
                    end
                end
                S_RUN: begin
                    if (dump_ready) begin
                        if (idx == LAST_IDX) begin
                            state <= S_DONE;
                        end
                        // Wraps to 0 after the last beat since NREGS is a power of two.
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign dump_valid = (state == S_RUN);
    assign dump_addr  = idx;
    assign dump_data  = regs[idx];
    assign dump_last  = dump_valid && (idx == LAST_IDX);
    assign dump_done  = (state == S_DONE);

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench for regfile_multiport: default build, a BYPASS=0 twin on the
// same stimulus, and a 16-entry 3-port build without a hardwired x0.
module tb_regfile_multiport;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  raddr;
    logic [63:0] rdata, rdata_nb;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        sb_set, sb_flush;
    logic [4:0]  sb_addr;
    logic [31:0] busy, busy_nb;
    logic        dump_req, dump_ready;
    logic        dump_valid, dump_last, dump_done;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;
    logic        nb_valid, nb_last, nb_done;
    logic [4:0]  nb_addr;
    logic [31:0] nb_data;

    logic [11:0] c_raddr;
    logic [95:0] c_rdata;
    logic        c_we;
    logic [3:0]  c_waddr;
    logic [31:0] c_wdata;
    logic [15:0] c_busy;
    logic        c_valid, c_last, c_done;
    logic [3:0]  c_addr;
    logic [31:0] c_data;

    int    n_vec  = 0;
    int    n_miss = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    regfile_multiport dut (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata),
        .we(we), .waddr(waddr), .wdata(wdata),
        .sb_set(sb_set), .sb_addr(sb_addr), .sb_flush(sb_flush), .busy(busy),
        .dump_req(dump_req), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_addr(dump_addr), .dump_data(dump_data), .dump_last(dump_last),
        .dump_done(dump_done)
    );

    regfile_multiport #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_nb),
        .we(we), .waddr(waddr), .wdata(wdata),
        .sb_set(sb_set), .sb_addr(sb_addr), .sb_flush(sb_flush), .busy(busy_nb),
        .dump_req(1'b0), .dump_valid(nb_valid), .dump_ready(1'b0),
        .dump_addr(nb_addr), .dump_data(nb_data), .dump_last(nb_last),
        .dump_done(nb_done)
    );

    regfile_multiport #(.NREGS(16), .NRD(3), .ZERO_REG(1'b0)) dut_c (
        .clk(clk), .rst(rst), .raddr(c_raddr), .rdata(c_rdata),
        .we(c_we), .waddr(c_waddr), .wdata(c_wdata),
        .sb_set(1'b0), .sb_addr(4'd0), .sb_flush(1'b0), .busy(c_busy),
        .dump_req(1'b0), .dump_valid(c_valid), .dump_ready(1'b0),
        .dump_addr(c_addr), .dump_data(c_data), .dump_last(c_last),
        .dump_done(c_done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_dump();
        for (int i = 0; i < 32; i++) begin
            beat_t b;
            b.addr = 5'(i);
            b.data = 32'(i * 32'h11);
            b.last = (i == 31);
            exp_q.push_back(b);
        end
    endtask

    // Random-ready consumer; stops after stop_after beats (or when the queue drains).
    task automatic run_dump(input int stop_after);
        int beats = 0;
        int cyc   = 0;
        while (exp_q.size() > 0 && cyc < 400 && beats != stop_after) begin
            @(negedge clk);
            dump_req   = (cyc == 6);
            dump_ready = 1'($urandom_range(0, 1));
            #1;
            if (dump_valid && dump_ready) begin
                beat_t e = exp_q.pop_front();
                check($sformatf("dump_addr[%0d]", beats), 64'(dump_addr), 64'(e.addr));
                check($sformatf("dump_data[%0d]", beats), 64'(dump_data), 64'(e.data));
                check($sformatf("dump_last[%0d]", beats), 64'(dump_last), 64'(e.last));
                beats++;
            end
            cyc++;
        end
        if (cyc >= 400) begin
            check("dump_timeout", 64'(exp_q.size()), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; dump_req = 1'b1; dump_ready = 1'b0;
        raddr = '0; we = 1'b0; waddr = '0; wdata = '0;
        sb_set = 1'b0; sb_addr = '0; sb_flush = 1'b0;
        c_raddr = '0; c_we = 1'b0; c_waddr = '0; c_wdata = '0;

        // Reset with a stray dump request
        @(negedge clk);
        rst = 1'b0; dump_req = 1'b0; raddr = {5'd31, 5'd5};
        #1;
        check("rst_rdata", rdata, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_dump_valid", 64'(dump_valid), 64'd0);
        check("rst_dump_done", 64'(dump_done), 64'd0);
        check("rst_dump_addr", 64'(dump_addr), 64'd0);

        // Write-to-read bypass
        @(negedge clk);
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr = {5'd31, 5'd5};
        #1;
        check("bypass_rdata0", 64'(rdata[31:0]), 64'hDEADBEEF);
        check("nobypass_rdata0", 64'(rdata_nb[31:0]), 64'd0);
        check("bypass_rdata1", 64'(rdata[63:32]), 64'd0);
        @(negedge clk);
        we = 1'b0;
        #1;
        check("stored_rdata0", 64'(rdata[31:0]), 64'hDEADBEEF);
        check("nobypass_stored", 64'(rdata_nb[31:0]), 64'hDEADBEEF);

        // x0 stays zero, its write and busy set are dropped
        @(negedge clk);
        we = 1'b1; waddr = 5'd0; wdata = 32'h1234; sb_set = 1'b1; sb_addr = 5'd0;
        raddr = {5'd0, 5'd0};
        #1;
        check("x0_write_cycle", rdata, 64'd0);
        @(negedge clk);
        we = 1'b0; sb_set = 1'b0;
        #1;
        check("x0_after", rdata, 64'd0);
        check("x0_busy", 64'(busy), 64'd0);

        // Scoreboard set / clear / collide / flush
        @(negedge clk);
        sb_set = 1'b1; sb_addr = 5'd7;
        @(negedge clk);
        sb_set = 1'b0;
        #1;
        check("sb_set7", 64'(busy), 64'h80);
        @(negedge clk);
        #1;
        check("sb_hold7", 64'(busy), 64'h80);
        @(negedge clk);
        we = 1'b1; waddr = 5'd7; wdata = 32'h77;
        @(negedge clk);
        we = 1'b0;
        #1;
        check("sb_clear7", 64'(busy), 64'd0);
        @(negedge clk);
        sb_set = 1'b1; sb_addr = 5'd7; we = 1'b1; waddr = 5'd7; wdata = 32'h777;
        @(negedge clk);
        sb_set = 1'b1; sb_addr = 5'd3; we = 1'b0;
        #1;
        check("sb_set_and_write7", 64'(busy), 64'h80);
        @(negedge clk);
        sb_set = 1'b0; raddr = {5'd5, 5'd7};
        #1;
        check("sb_set3", 64'(busy), 64'h88);
        check("read_x7", 64'(rdata[31:0]), 64'h777);
        check("read_x5", 64'(rdata[63:32]), 64'hDEADBEEF);
        @(negedge clk);
        sb_flush = 1'b1; sb_set = 1'b1; sb_addr = 5'd9;
        @(negedge clk);
        sb_flush = 1'b0; sb_set = 1'b0;
        #1;
        check("sb_flush", 64'(busy), 64'd0);

        // 16-entry, 3-port, ordinary x0
        @(negedge clk);
        c_we = 1'b1; c_waddr = 4'd0; c_wdata = 32'hA5A50001;
        @(negedge clk);
        c_waddr = 4'd15; c_wdata = 32'h12345678;
        @(negedge clk);
        c_waddr = 4'd3; c_wdata = 32'hCAFE0003;
        @(negedge clk);
        c_we = 1'b0; c_raddr = {4'd3, 4'd15, 4'd0};
        #1;
        check("c_port0_x0", 64'(c_rdata[31:0]), 64'hA5A50001);
        check("c_port1_x15", 64'(c_rdata[63:32]), 64'h12345678);
        check("c_port2_x3", 64'(c_rdata[95:64]), 64'hCAFE0003);

        // Preload x_i = i*0x11, then a full dump with random backpressure
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            we = 1'b1; waddr = 5'(i); wdata = 32'(i * 32'h11);
        end
        @(negedge clk);
        we = 1'b0; dump_req = 1'b1;
        push_dump();
        run_dump(-1);
        @(negedge clk);
        dump_req = 1'b0; dump_ready = 1'b0;
        #1;
        check("dump_done_pulse", 64'(dump_done), 64'd1);
        check("dump_valid_in_done", 64'(dump_valid), 64'd0);
        @(negedge clk);
        #1;
        check("dump_done_once", 64'(dump_done), 64'd0);
        check("dump_idle_valid", 64'(dump_valid), 64'd0);

        // Second dump aborted by reset after beat 10
        @(negedge clk);
        dump_req = 1'b1;
        push_dump();
        run_dump(11);
        @(negedge clk);
        rst = 1'b1; dump_req = 1'b0; dump_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0; raddr = {5'd31, 5'd7};
        exp_q.delete();
        #1;
        check("abort_valid", 64'(dump_valid), 64'd0);
        check("abort_done", 64'(dump_done), 64'd0);
        check("abort_regs_cleared", rdata, 64'd0);
        @(negedge clk);
        #1;
        check("abort_no_done", 64'(dump_done), 64'd0);
        check("abort_idle", 64'(dump_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
